// File: rtl/spi_pkg.sv
// spi_pkg: shared FSM states, command codes and frame constants for the SPI master
package spi_pkg;
   typedef enum logic [2:0] {ST_IDLE, ST_LEAD, ST_SHIFT, ST_TURN, ST_RECV, ST_GAP} state_t;
   localparam logic [1:0] CMD_WR_ADDR = 2'b00;
   localparam logic [1:0] CMD_WR_DATA = 2'b01;
   localparam logic [1:0] CMD_RD_ADDR = 2'b10;
   localparam logic [1:0] CMD_RD_DATA = 2'b11;
   localparam int FRAME_BITS = 11;
   localparam int RX_BITS = 8;
   function automatic int max4(input int a, input int b, input int c, input int d);
      int ab, cd;
      ab = (a > b) ? a : b;
      cd = (c > d) ? c : d;
      return (ab > cd) ? ab : cd;
   endfunction
endpackage

// File: rtl/spi_shift_reg.sv
// spi_shift_reg: transmit word shifter and receive byte shifter
// Ports: i_load latches i_word, i_shift moves tx left (o_tx_msb is the bit on the wire),
// i_capture shifts i_miso into rx; o_rx_nxt is the byte as it will look after this capture.
module spi_shift_reg
   import spi_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_load,
   input  logic                  i_shift,
   input  logic                  i_capture,
   input  logic [FRAME_BITS-2:0] i_word,
   input  logic                  i_miso,
   output logic                  o_tx_msb,
   output logic [RX_BITS-1:0]    o_rx_nxt
);
   logic [FRAME_BITS-2:0] r_tx;
   logic [RX_BITS-2:0]    r_rx;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         r_tx <= '0;
         r_rx <= '0;
      end else begin
         if (i_load) r_tx <= i_word;
         else if (i_shift) r_tx <= {r_tx[FRAME_BITS-3:0], 1'b0};
         if (i_capture) r_rx <= o_rx_nxt[RX_BITS-2:0];
      end
   assign o_tx_msb = r_tx[FRAME_BITS-2];
   assign o_rx_nxt = {r_rx, i_miso};
endmodule

// File: rtl/spi_master_ctrl.sv
// spi_master_ctrl: SPI frame controller (lead, 11-slot command/payload, optional turnaround + 8-bit read, gap)
// Ports: start/cmd/payload request a frame; busy, done, rd_data/rd_valid report it;
// SS_n/MOSI/MISO are the SPI wires. Reset is asynchronous, active high.
module spi_master_ctrl
   import spi_pkg::*;
#(
   parameter int LEAD_CYC = 1,
   parameter int TURN_CYC = 2,
   parameter int GAP_CYC  = 2
)(
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [1:0] cmd,
   input  logic [7:0] payload,
   output logic       busy,
   output logic       done,
   output logic [7:0] rd_data,
   output logic       rd_valid,
   output logic       SS_n,
   output logic       MOSI,
   input  logic       MISO
);
   localparam int CW = $clog2(max4(FRAME_BITS, LEAD_CYC, TURN_CYC, GAP_CYC) + 1);
   // zero-length phases are skipped by jumping straight past them
   localparam state_t ST_FIRST = (LEAD_CYC > 0) ? ST_LEAD : ST_SHIFT;
   localparam state_t ST_TAIL  = (GAP_CYC > 0) ? ST_GAP : ST_IDLE;
   localparam state_t ST_RXGO  = (TURN_CYC > 0) ? ST_TURN : ST_RECV;
   state_t         r_state, w_nxt;
   logic [CW-1:0]  r_cnt;
   logic [1:0]     r_cmd;
   logic [7:0]     r_rd_data;
   logic           w_last, w_load, w_done, w_rd, w_tx_msb;
   logic [7:0]     w_rx_nxt;
   assign w_rd = r_cmd == CMD_RD_DATA;
   assign w_last = (r_state == ST_LEAD  && r_cnt == CW'(LEAD_CYC - 1))   ||
                   (r_state == ST_SHIFT && r_cnt == CW'(FRAME_BITS - 1)) ||
                   (r_state == ST_TURN  && r_cnt == CW'(TURN_CYC - 1))   ||
                   (r_state == ST_RECV  && r_cnt == CW'(RX_BITS - 1))    ||
                   (r_state == ST_GAP   && r_cnt == CW'(GAP_CYC - 1));
   // done is the last cycle of the frame, so a start seen here chains the next frame with no idle cycle
   always_comb begin
      w_nxt = r_state;
      if (w_last)
         case (r_state)
            ST_LEAD:  w_nxt = ST_SHIFT;
            ST_SHIFT: w_nxt = w_rd ? ST_RXGO : ST_TAIL;
            ST_TURN:  w_nxt = ST_RECV;
            ST_RECV:  w_nxt = ST_TAIL;
            default:  w_nxt = ST_IDLE;
         endcase
      w_done = r_state != ST_IDLE && w_nxt == ST_IDLE;
      w_load = start && (r_state == ST_IDLE || w_done);
      if (w_load) w_nxt = ST_FIRST;
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         r_state   <= ST_IDLE;
         r_cnt     <= '0;
         r_cmd     <= '0;
         r_rd_data <= '0;
      end else begin
         r_state <= w_nxt;
         r_cnt   <= (r_state == ST_IDLE || w_nxt != r_state || w_load) ? '0 : r_cnt + 1'b1;
         if (w_load) r_cmd <= cmd;
         if (r_state == ST_RECV && w_last) r_rd_data <= w_rx_nxt;
      end
   // slot 0 repeats word[9], so shifting starts only after slot 1
   spi_shift_reg u_sr (
      .clk       (clk),
      .rst       (rst),
      .i_load    (w_load),
      .i_shift   (r_state == ST_SHIFT && r_cnt != '0),
      .i_capture (r_state == ST_RECV),
      .i_word    ({cmd, payload}),
      .i_miso    (MISO),
      .o_tx_msb  (w_tx_msb),
      .o_rx_nxt  (w_rx_nxt)
   );
   assign busy     = r_state != ST_IDLE;
   assign done     = w_done;
   assign rd_valid = w_done && w_rd;
   assign rd_data  = r_rd_data;
   assign SS_n     = r_state == ST_IDLE || r_state == ST_GAP;
   assign MOSI     = r_state == ST_SHIFT && w_tx_msb;
endmodule

// File: tb/tb_spi_master_ctrl.sv
// tb_spi_master_ctrl: directed cycle-by-cycle checks of spi_master_ctrl with default parameters
module tb_spi_master_ctrl;
   logic       clk = 1'b0;
   logic       rst, start, MISO;
   logic [1:0] cmd;
   logic [7:0] payload;
   logic       busy, done, rd_valid, SS_n, MOSI;
   logic [7:0] rd_data;
   int         n_vec = 0;
   int         n_bad = 0;
   spi_master_ctrl dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .cmd      (cmd),
      .payload  (payload),
      .busy     (busy),
      .done     (done),
      .rd_data  (rd_data),
      .rd_valid (rd_valid),
      .SS_n     (SS_n),
      .MOSI     (MOSI),
      .MISO     (MISO)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   // one frame, checked every cycle; returns in the done cycle with start untouched
   task automatic frame(input logic [1:0] c, input logic [7:0] p, input logic [7:0] rx, input bit poke);
      logic [9:0] w;
      bit         rd;
      int         n, low;
      w = {c, p};
      rd = c == 2'b11;
      n = rd ? 24 : 14;
      low = rd ? 22 : 12;
      start = 1'b1;
      cmd = c;
      payload = p;
      for (int k = 1; k <= n; k++) begin
         @(posedge clk); #1;
         if (k == 1) start = 1'b0;
         if (poke && k == 6) begin start = 1'b1; cmd = 2'b10; payload = 8'h00; end
         if (poke && k == 7) start = 1'b0;
         MISO = (rd && k >= 15 && k <= 22) ? rx[22-k] : 1'b1;
         chk($sformatf("ss c%0d k%0d", c, k), SS_n, k > low);
         chk($sformatf("mosi c%0d k%0d", c, k), MOSI,
             (k >= 2 && k <= 12) ? ((k == 2) ? w[9] : w[12-k]) : 1'b0);
         chk($sformatf("busy c%0d k%0d", c, k), busy, 1);
         chk($sformatf("done c%0d k%0d", c, k), done, k == n);
         chk($sformatf("rv c%0d k%0d", c, k), rd_valid, rd && k == n);
         if (rd && k == n) chk("rd_data", rd_data, rx);
      end
   endtask
   task automatic idle_chk(input string tag);
      @(posedge clk); #1;
      chk({tag, " busy"}, busy, 0);
      chk({tag, " done"}, done, 0);
      chk({tag, " rv"}, rd_valid, 0);
      chk({tag, " ss"}, SS_n, 1);
      chk({tag, " mosi"}, MOSI, 0);
   endtask
   initial begin
      #100000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end
   initial begin
      rst = 1'b1; start = 1'b0; cmd = 2'b00; payload = 8'h00; MISO = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst ss", SS_n, 1);
      chk("rst mosi", MOSI, 0);
      chk("rst busy", busy, 0);
      chk("rst done", done, 0);
      chk("rst rv", rd_valid, 0);
      chk("rst rd_data", rd_data, 8'h00);
      rst = 1'b0;
      frame(2'b00, 8'hFF, 8'h00, 0);
      idle_chk("post_wa");
      frame(2'b01, 8'hA5, 8'h00, 0);
      idle_chk("post_wd");
      frame(2'b11, 8'h12, 8'h3C, 0);
      idle_chk("post_rd");
      chk("rd_data hold", rd_data, 8'h3C);
      frame(2'b01, 8'h5A, 8'h00, 1);
      idle_chk("post_poke1");
      idle_chk("post_poke2");
      frame(2'b10, 8'h81, 8'h00, 0);
      frame(2'b11, 8'h40, 8'hC3, 0);
      idle_chk("post_b2b");
      start = 1'b1; cmd = 2'b01; payload = 8'hA5;
      repeat (7) begin @(posedge clk); #1; start = 1'b0; end
      chk("pre_rst mosi", MOSI, 1);
      chk("pre_rst ss", SS_n, 0);
      rst = 1'b1;
      #1;
      chk("mid_rst ss", SS_n, 1);
      chk("mid_rst mosi", MOSI, 0);
      chk("mid_rst busy", busy, 0);
      chk("mid_rst done", done, 0);
      @(posedge clk); #1;
      chk("held_rst done", done, 0);
      chk("held_rst ss", SS_n, 1);
      rst = 1'b0;
      frame(2'b01, 8'hA5, 8'h00, 0);
      idle_chk("post_rst_frame");
      chk("rd_data cleared", rd_data, 8'h00);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule

// File: doc/spi_master_ctrl.md
SPI_MASTER_CTRL -- requirements
Module: spi_master_ctrl

Interface
REQ-001 SHALL have parameter LEAD_CYC, default 1, meaning clk cycles with SS_n low before the first MOSI bit slot.
REQ-002 SHALL have parameter TURN_CYC, default 2, meaning clk cycles between the last MOSI slot and the first MISO sample on read-data frames.
REQ-003 SHALL have parameter GAP_CYC, default 2, meaning minimum clk cycles with SS_n high between frames.
REQ-004 SHALL have port clk, input, 1, meaning the single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst, input, 1, meaning the asynchronous, active-high reset.
REQ-006 SHALL have port start, input, 1, meaning a one-cycle transaction request.
REQ-007 SHALL have port cmd, input, 2, meaning the frame type: 00 wr-addr, 01 wr-data, 10 rd-addr, 11 rd-data.
REQ-008 SHALL have port payload, input, 8, meaning the address or data byte.
REQ-009 SHALL have port busy, output, 1, meaning a frame is in progress.
REQ-010 SHALL have port done, output, 1, meaning a one-cycle frame-complete pulse.
REQ-011 SHALL have port rd_data, output, 8, meaning the byte captured on a rd-data frame.
REQ-012 SHALL have port rd_valid, output, 1, meaning a one-cycle pulse, coincident with done, when rd_data is updated.
REQ-013 SHALL have port SS_n, output, 1, meaning the active-low slave select driven to the SPI slave.
REQ-014 SHALL have port MOSI, output, 1, meaning serial data to the slave.
REQ-015 SHALL have port MISO, input, 1, meaning serial data from the slave.

Function
REQ-016 SHALL accept start only when busy=0, latching cmd and payload into a 10-bit word {cmd,payload} on that edge; start while busy=1 SHALL be ignored.
REQ-017 SHALL implement the states IDLE, LEAD, SHIFT, TURN, RECV and GAP; transitions: IDLE->LEAD on an accepted start; LEAD->SHIFT after LEAD_CYC cycles; SHIFT->TURN after 11 slots if cmd=11, otherwise SHIFT->GAP; TURN->RECV after TURN_CYC cycles; RECV->GAP after 8 samples; GAP->IDLE after GAP_CYC cycles.
REQ-018 SHALL drive SS_n=0 in LEAD, SHIFT, TURN and RECV, and SS_n=1 in IDLE and GAP.
REQ-019 SHALL, in SHIFT, drive 11 slots of one clk each: slot0 = word[9] (command-select bit), then slots 1..10 = word[9] down to word[0] (MSB first).
REQ-020 SHALL hold MOSI=0 outside SHIFT.
REQ-021 SHALL, in RECV, sample MISO on 8 consecutive rising edges into rd_data[7] down to rd_data[0] (MSB first), updating rd_data only at frame end.
REQ-022 SHALL set busy=1 from the cycle after start is accepted until IDLE is re-entered.
REQ-023 SHALL pulse done for one cycle on the GAP->IDLE transition; rd_valid SHALL pulse on the same cycle only for cmd=11.
REQ-024 SHALL accept a start asserted on the same cycle that done is high (back-to-back frames), with no extra idle cycle.
REQ-025 SHALL size its counters to cover max(11, LEAD_CYC, TURN_CYC, GAP_CYC) without wrap; a parameter value of 0 SHALL skip that state.
REQ-026 SHALL give a frame length of LEAD_CYC+11+GAP_CYC cycles for non-read-data frames, plus TURN_CYC+8 cycles for rd-data frames.

Reset
REQ-027 SHALL, on rst=1 asynchronously, force the state to IDLE with SS_n=1, MOSI=0, busy=0, done=0, rd_valid=0, rd_data=8'h00 and all counters at 0.
REQ-028 SHALL, on reset mid-frame, abort the frame immediately with no done pulse, and SHALL accept a start on the first edge after rst deasserts.

Structure
REQ-029 SHALL take the state encoding, the cmd codes (CMD_WR_ADDR=00, CMD_WR_DATA=01, CMD_RD_ADDR=10, CMD_RD_DATA=11) and the constants FRAME_BITS=11 and RX_BITS=8 from the shared package spi_pkg.
REQ-030 SHALL contain one sub-module, spi_shift_reg, holding the 10-bit transmit shift register and the 8-bit receive shift register, with load, shift and capture enables.

Verification
REQ-031 SHALL cover: start, cmd=00, payload=8'hFF -> SS_n low for 1+11 cycles, MOSI slots 0,0,0,1,1,1,1,1,1,1,1, done after 2 gap cycles, rd_valid=0.
REQ-032 SHALL cover: cmd=01, payload=8'hA5 -> MOSI slots 0,0,1,1,0,1,0,0,1,0,1, with a frame length of 14 cycles.
REQ-033 SHALL cover: cmd=11 with a slave model returning 8'h3C after 2 turnaround cycles -> rd_data=8'h3C, rd_valid and done high together, a frame length of 24 cycles.
REQ-034 SHALL cover: start re-pulsed while busy=1 with cmd=10 -> ignored, the original frame completes unchanged, exactly one done.
REQ-035 SHALL cover: rst asserted in SHIFT slot 5 -> SS_n=1 and MOSI=0 in the same cycle, no done; a new start after release yields a full correct frame.
REQ-036 SHALL cover: a start held on the cycle done is high -> the next LEAD begins immediately and SS_n returns low after exactly GAP_CYC high cycles.
